mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single memory port shared by fetch/data/stack requesters, with access timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority fetch > data > stack.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    gnt,
    output logic [2:0]    done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state, owner, win;
    logic [7:0] cnt;
    logic       abort, sel_we;

    // Requesters hold their operands stable until done, so the port is a plain mux.
    always_comb begin
        sel_we    = (owner == 2'd2) ? we[2]  : (owner == 2'd1) ? we[1]  : we[0];
        mem_addr  = (owner == 2'd2) ? addr2  : (owner == 2'd1) ? addr1  : addr0;
        mem_wdata = (owner == 2'd2) ? wdata2 : (owner == 2'd1) ? wdata1 : wdata0;
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr, p1, p2;
    always_comb begin
        p1  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        p2  = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        win = req[p1] ? p1 : req[p2] ? p2 : ptr;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= 2'd2;
        else if (state == IDLE && |req)
            ptr <= win;
    end
`else
    assign win = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 2'd0;
            cnt   <= 8'd0;
            abort <= 1'b0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    owner <= win;
                    cnt   <= 8'(TIMEOUT);
                    abort <= 1'b0;
                    state <= BUSY;
                end
                BUSY: if (mem_ready) begin
                    if (!sel_we)
                        rdata <= mem_rdata;
                    state <= RESP;
                end else if (cnt == 8'd0) begin
                    abort <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == BUSY) || (state == RESP);
    assign gnt    = busy ? (3'b001 << owner) : 3'b000;
    assign done   = (state == RESP) ? (3'b001 << owner) : 3'b000;
    assign err    = (state == RESP) && abort;
    assign mem_en = (state == BUSY);
    assign mem_we = mem_en && sel_we;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with TIMEOUT=3.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = 3'b000, we = 3'b000;
    logic [15:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
    logic [2:0]  gnt, done;
    logic        err, busy, mem_en, mem_we, mem_ready = 1'b0;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata = '0;
    int          n_chk = 0, n_fail = 0;

    mem_port_arbiter #(.AW(16), .DW(16), .TIMEOUT(3)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({gnt, done, err, busy, mem_en, mem_we} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b done=%b err=%b busy=%b en=%b we=%b, need all 0", gnt, done, err, busy, mem_en, mem_we);
        end
        n_chk++;
        if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h need 0000", rdata); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch_read();
        req = 3'b001; addr0 = 16'h0040;
        tick();
        n_chk++;
        if ({gnt, mem_en, mem_we, busy} !== 6'b001101 || mem_addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL fetch_busy: got gnt=%b en=%b we=%b busy=%b addr=%h need 001 1 0 1 0040", gnt, mem_en, mem_we, busy, mem_addr);
        end
        req = 3'b000;
        tick();
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        n_chk++;
        if (done !== 3'b001 || err !== 1'b0 || rdata !== 16'hBEEF || mem_en !== 1'b0 || gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL fetch_done: got done=%b err=%b rdata=%h en=%b gnt=%b need 001 0 beef 0 001", done, err, rdata, mem_en, gnt);
        end
        tick();
        n_chk++;
        if ({gnt, done, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL fetch_idle: got gnt=%b done=%b busy=%b need 0", gnt, done, busy);
        end
    endtask

    task automatic test_stack_write();
        req = 3'b100; we = 3'b100; wdata2 = 16'h1234; addr2 = 16'h00FE; mem_rdata = 16'h5555;
        tick();
        n_chk++;
        if (gnt !== 3'b100 || mem_we !== 1'b1 || mem_addr !== 16'h00FE || mem_wdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL stack_port: got gnt=%b we=%b addr=%h wdata=%h need 100 1 00fe 1234", gnt, mem_we, mem_addr, mem_wdata);
        end
        req = 3'b000; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_chk++;
        if (done !== 3'b100 || err !== 1'b0 || rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL stack_done: got done=%b err=%b rdata=%h need 100 0 beef", done, err, rdata);
        end
        we = 3'b000;
        tick();
    endtask

    task automatic test_arbitration();
        logic [2:0] exp [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        req = 3'b111; mem_ready = 1'b1; mem_rdata = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (gnt !== exp[i] || mem_en !== 1'b1) begin
                n_fail++;
                $display("FAIL arb_gnt%0d: got gnt=%b en=%b need %b 1", i, gnt, mem_en, exp[i]);
            end
            tick();
            n_chk++;
            if (done !== exp[i]) begin n_fail++; $display("FAIL arb_done%0d: got %b need %b", i, done, exp[i]); end
            if (i == 3) req = 3'b000;
            tick();
            n_chk++;
            if (gnt !== 3'b000) begin n_fail++; $display("FAIL arb_idle%0d: got gnt=%b need 000", i, gnt); end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        req = 3'b010; addr1 = 16'h0222;
        tick();
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (mem_en !== 1'b1 || done !== 3'b000) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: got en=%b done=%b need 1 000", i, mem_en, done);
            end
        end
        tick();
        n_chk++;
        if (done !== 3'b010 || err !== 1'b1 || rdata !== 16'h7777) begin
            n_fail++;
            $display("FAIL timeout_abort: got done=%b err=%b rdata=%h need 010 1 7777", done, err, rdata);
        end
        tick();
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got err=%b busy=%b need 0 0", err, busy); end
        req = 3'b010;
        tick();
        req = 3'b000; mem_ready = 1'b1; mem_rdata = 16'hA5A5;
        tick();
        mem_ready = 1'b0;
        n_chk++;
        if (done !== 3'b010 || err !== 1'b0 || rdata !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL timeout_next: got done=%b err=%b rdata=%h need 010 0 a5a5", done, err, rdata);
        end
        tick();
    endtask

    task automatic test_ready_at_zero();
        req = 3'b001;
        tick();
        req = 3'b000;
        repeat (3) tick();
        mem_ready = 1'b1; mem_rdata = 16'h0F0F;
        tick();
        mem_ready = 1'b0;
        n_chk++;
        if (done !== 3'b001 || err !== 1'b0 || rdata !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL ready_at_zero: got done=%b err=%b rdata=%h need 001 0 0f0f", done, err, rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        req = 3'b100; we = 3'b100;
        tick();
        req = 3'b000;
        tick();
        reset = 1'b0;
        #1;
        n_chk++;
        if ({gnt, done, err, busy, mem_en, mem_we} !== 10'b0 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: got gnt=%b done=%b err=%b busy=%b en=%b we=%b rdata=%h need all 0", gnt, done, err, busy, mem_en, mem_we, rdata);
        end
        we = 3'b000;
        repeat (2) begin
            tick();
            n_chk++;
            if (done !== 3'b000) begin n_fail++; $display("FAIL reset_hold_done: got %b need 000", done); end
        end
        reset = 1'b1;
        tick();
        req = 3'b010;
        tick();
        n_chk++;
        if (gnt !== 3'b010 || mem_addr !== 16'h0222) begin
            n_fail++;
            $display("FAIL reset_regrant: got gnt=%b addr=%h need 010 0222", gnt, mem_addr);
        end
        req = 3'b000; mem_ready = 1'b1; mem_rdata = 16'h3C3C;
        tick();
        mem_ready = 1'b0;
        n_chk++;
        if (done !== 3'b010 || rdata !== 16'h3C3C) begin
            n_fail++;
            $display("FAIL reset_regrant_done: got done=%b rdata=%h need 010 3c3c", done, rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_stack_write();
        test_arbitration();
        test_timeout();
        test_ready_at_zero();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
